// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if -- value/load handshake and display-pin bundle for the
// four-digit seven-segment scan controller.
//
// Signals:
//   value_i     [15:0] value to display, nibble k drives digit k
//   load_i             one-cycle strobe capturing value_i into the pending buffer
//   pending_o          high while a loaded value awaits the frame commit
//   anode_o     [3:0]  one-hot digit select, active-high
//   seg_o       [6:0]  segments {g,f,e,d,c,b,a}, active-high
//   digit_idx_o [1:0]  current slot index
//   frame_o            one-cycle pulse after the edge where the index wraps 3->0
//
// Modports:
//   master - value source / display observer (drives value_i, load_i)
//   slave  - the scan controller itself
interface digit_scan_ctrl_if;
  logic [15:0] value_i;
  logic        load_i;
  logic        pending_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  modport master (
    output value_i,
    output load_i,
    input  pending_o,
    input  anode_o,
    input  seg_o,
    input  digit_idx_o,
    input  frame_o
  );

  modport slave (
    input  value_i,
    input  load_i,
    output pending_o,
    output anode_o,
    output seg_o,
    output digit_idx_o,
    output frame_o
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl -- time-multiplexed scan controller for a 4-digit
// seven-segment display. A prescaler divides clk into digit slots of TICKS
// cycles; the slot index walks 0->1->2->3 and the matching nibble of the
// shown value is decoded to segments. New values are double-buffered in a
// pending register and committed only when the index wraps 3->0, so a frame
// never mixes old and new digits.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - digit_scan_ctrl_if.slave (value_i, load_i, pending_o, anode_o,
//          seg_o, digit_idx_o, frame_o)
//
// Parameters:
//   DIV_W     - prescaler width
//   TICKS     - cycles per digit slot, 2 <= TICKS <= 2**DIV_W
//   BLANK_CYC - dead-time cycles at the start of each slot, 0 <= BLANK_CYC < TICKS
//
// Optional feature macro: LEAD_ZERO_BLANK_EN
//   Defined   - digits 1..3 are suppressed (anode and segments off) while
//               shown nibbles k..3 are all zero; digit 0 is always driven.
//   Undefined - all four digits are always driven.
//
// All outputs are registered. The output flops are loaded from the decode of
// the *next* register state, so they are cycle-for-cycle identical to a
// combinational decode of the state registers.
module digit_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int TICKS     = 50000,
  parameter int BLANK_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  digit_scan_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICKS - 1);
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
  localparam logic [3:0]       RST_ANODE = (BLANK_CYC > 0) ? 4'b0000 : 4'b0001;

  // Hex digit to active-high {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = 7'h3F;
      4'h1:    hex_seg = 7'h06;
      4'h2:    hex_seg = 7'h5B;
      4'h3:    hex_seg = 7'h4F;
      4'h4:    hex_seg = 7'h66;
      4'h5:    hex_seg = 7'h6D;
      4'h6:    hex_seg = 7'h7D;
      4'h7:    hex_seg = 7'h07;
      4'h8:    hex_seg = 7'h7F;
      4'h9:    hex_seg = 7'h6F;
      4'hA:    hex_seg = 7'h77;
      4'hB:    hex_seg = 7'h7C;
      4'hC:    hex_seg = 7'h39;
      4'hD:    hex_seg = 7'h5E;
      4'hE:    hex_seg = 7'h79;
      4'hF:    hex_seg = 7'h71;
      default: hex_seg = 7'h00;
    endcase
  endfunction

  // 2-to-4 one-hot select decode.
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    case (sel)
      2'd0:    onehot4 = 4'b0001;
      2'd1:    onehot4 = 4'b0010;
      2'd2:    onehot4 = 4'b0100;
      2'd3:    onehot4 = 4'b1000;
      default: onehot4 = 4'b0000;
    endcase
  endfunction

`ifdef LEAD_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic lead_zero(input logic [1:0] sel, input logic [15:0] val);
    case (sel)
      2'd1:    lead_zero = (val[15:4]  == 12'h000);
      2'd2:    lead_zero = (val[15:8]  == 8'h00);
      2'd3:    lead_zero = (val[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  endfunction
`endif

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shown_q, shown_d;
  logic [15:0]      pend_q, pend_d;
  logic             pending_q, pending_d;
  logic             frame_q, frame_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;

  logic tick_s;
  logic commit_s;
  logic blank_s;
  logic suppress_s;

  // Next-state logic: prescaler, slot index, double buffer, output decode.
  always_comb begin
    tick_s   = (cnt_q == TICK_LAST);
    commit_s = tick_s && (idx_q == 2'd3);

    if (tick_s) begin
      cnt_d = {DIV_W{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1'b1);
      idx_d = idx_q;
    end

    // The commit reads the old pend, so a load on the commit edge stays pending.
    if (commit_s && pending_q) begin
      shown_d = pend_q;
    end else begin
      shown_d = shown_q;
    end

    if (bus.load_i) begin
      pend_d    = bus.value_i;
      pending_d = 1'b1;
    end else if (commit_s) begin
      pend_d    = pend_q;
      pending_d = 1'b0;
    end else begin
      pend_d    = pend_q;
      pending_d = pending_q;
    end

    frame_d = commit_s;

    blank_s = (BLANK_CYC > 0) && (cnt_d < BLANK_LIM);

`ifdef LEAD_ZERO_BLANK_EN
    suppress_s = lead_zero(idx_d, shown_d);
`else
    suppress_s = 1'b0;
`endif

    if (suppress_s) begin
      anode_d = 4'b0000;
      seg_d   = 7'h00;
    end else if (blank_s) begin
      anode_d = 4'b0000;
      seg_d   = hex_seg(shown_d[{idx_d, 2'b00} +: 4]);
    end else begin
      anode_d = onehot4(idx_d);
      seg_d   = hex_seg(shown_d[{idx_d, 2'b00} +: 4]);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {DIV_W{1'b0}};
      idx_q     <= 2'd0;
      shown_q   <= 16'h0000;
      pend_q    <= 16'h0000;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      anode_q   <= RST_ANODE;
      seg_q     <= 7'h3F;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shown_q   <= shown_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.pending_o   = pending_q;
  assign bus.anode_o     = anode_q;
  assign bus.seg_o       = seg_q;
  assign bus.digit_idx_o = idx_q;
  assign bus.frame_o     = frame_q;

endmodule
